// File: rtl/esdi_pkg.sv
// Shared definitions for the ESDI write-path front end: FSM encoding and byte/keep sizing.
// No logic of its own; imported by the deserializer.
package esdi_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic int keep_width(input int data_width);
    return data_width / BYTE_BITS;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head word is readable combinationally and a write shows up on the read side one cycle later.
// Backpressure: writes while full are ignored unless a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_rd  = rd_rdy && !empty;
  assign do_wr  = wr_vld && (!full || do_rd);
  // Head is forced to zero when empty so the stream outputs rest at 0.
  assign rd_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/esdi_write_deserializer.sv
// ESDI write-path front end: syncs gate/clock/data pins, hunts the sync byte, packs sector bytes into stream words.
// Latency: pin to edge-detect 3 cycles, push 1 cycle after the completing edge; backpressure: full FIFO drops words (sticky overflow).
module esdi_write_deserializer
  import esdi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic                              enable,
  input  logic                              clear_status,
  input  logic [7:0]                        sync_pattern,
  input  logic [LEN_WIDTH-1:0]              sector_bytes,
  input  logic [ID_WIDTH-1:0]               sector_number,
  input  logic                              esdi_write_gate,
  input  logic                              esdi_write_clock,
  input  logic                              esdi_write_data,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [keep_width(DATA_WIDTH)-1:0] m_tkeep,
  output logic                              m_tlast,
  output logic [ID_WIDTH-1:0]               m_tid,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic                              short_error
);

  localparam int KW = keep_width(DATA_WIDTH);
  localparam int LW = (KW > 1) ? $clog2(KW) : 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   tid;
    logic                  last;
    logic [KW-1:0]         keep;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  logic gate_s1, gate_s2;
  logic wclk_s1, wclk_s2, wclk_s3;
  logic wdat_s1, wdat_s2;
  logic bit_vld, bit_dat, gate_off;

  state_t state, state_nxt;
  logic   sync_hit, byte_take, abort;

  logic [BYTE_BITS-2:0]  shift_q;
  logic [2:0]            bit_cnt;
  logic [LEN_WIDTH-1:0]  byte_cnt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [LW-1:0]         lane_cnt;
  logic [7:0]            byte_dat;
  logic                  last_byte, word_full;
  logic [DATA_WIDTH-1:0] word_fill;
  logic [KW-1:0]         keep_full, keep_part;
  word_t                 full_word, part_word;
  logic                  push_vld;
  word_t                 push_dat;
  word_t                 head;
  logic                  fifo_full, fifo_empty;
  logic                  overflow_q, short_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      {gate_s1, gate_s2}          <= '0;
      {wclk_s1, wclk_s2, wclk_s3} <= '0;
      {wdat_s1, wdat_s2}          <= '0;
    end else begin
      gate_s1 <= esdi_write_gate;
      gate_s2 <= gate_s1;
      wclk_s1 <= esdi_write_clock;
      wclk_s2 <= wclk_s1;
      wclk_s3 <= wclk_s2;
      wdat_s1 <= esdi_write_data;
      wdat_s2 <= wdat_s1;
    end
  end

  assign bit_vld  = wclk_s2 && !wclk_s3;
  assign bit_dat  = wdat_s2;
  assign gate_off = gate_s2;  // gate pin is active-low
  assign byte_dat = {shift_q, bit_dat};

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable && !gate_off && sector_bytes != '0) state_nxt = HUNT;
      HUNT:  if (gate_off) state_nxt = IDLE;
             else if (bit_vld && byte_dat == sync_pattern) state_nxt = DATA;
      DATA:  if (gate_off) state_nxt = DRAIN;
             else if (bit_vld && bit_cnt == 3'd7 && last_byte) state_nxt = DRAIN;
      DRAIN: if (gate_off) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    sync_hit  = (state == HUNT) && !gate_off && bit_vld && (byte_dat == sync_pattern);
    byte_take = (state == DATA) && !gate_off && bit_vld && (bit_cnt == 3'd7);
    abort     = (state == DATA) && gate_off;
  end

  assign last_byte = (byte_cnt + LEN_WIDTH'(1)) == len_q;
  assign word_full = (lane_cnt == LW'(KW - 1));

  always_comb begin
    word_fill = word_q;
    word_fill[int'(lane_cnt) * BYTE_BITS +: BYTE_BITS] = byte_dat;
    keep_full = '0;
    keep_part = '0;
    for (int i = 0; i < KW; i++) begin
      keep_full[i] = (i <= int'(lane_cnt));
      keep_part[i] = (i < int'(lane_cnt));
    end
    full_word = '{tid: id_q, last: last_byte, keep: keep_full, data: word_fill};
    part_word = '{tid: id_q, last: 1'b1, keep: keep_part, data: word_q};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      len_q    <= '0;
      id_q     <= '0;
      word_q   <= '0;
      lane_cnt <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      push_vld <= 1'b0;
      if (state == IDLE) shift_q <= '0;
      else if ((state == HUNT || state == DATA) && !gate_off && bit_vld) shift_q <= byte_dat[6:0];
      if (sync_hit) begin
        len_q    <= sector_bytes;
        id_q     <= sector_number;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        lane_cnt <= '0;
        word_q   <= '0;
      end
      if ((state == DATA) && !gate_off && bit_vld) bit_cnt <= bit_cnt + 3'd1;
      if (byte_take) begin
        byte_cnt <= byte_cnt + LEN_WIDTH'(1);
        if (last_byte || word_full) begin
          push_vld <= 1'b1;
          push_dat <= full_word;
          word_q   <= '0;
          lane_cnt <= '0;
        end else begin
          word_q   <= word_fill;
          lane_cnt <= lane_cnt + LW'(1);
        end
      end
      // Early gate release: flush whatever whole bytes are pending as the closing word.
      if (abort) begin
        push_vld <= 1'b1;
        push_dat <= part_word;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      overflow_q <= (push_vld && fifo_full && !m_tready) || (overflow_q && !clear_status);
      short_q    <= abort || (short_q && !clear_status);
    end
  end

  sync_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (aclk),
    .rst    (areset),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .rd_rdy (m_tready),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign m_tvalid    = !fifo_empty;
  assign m_tdata     = head.data;
  assign m_tkeep     = head.keep;
  assign m_tlast     = head.last;
  assign m_tid       = head.tid;
  assign done        = push_vld && push_dat.last;
  assign overflow    = overflow_q;
  assign short_error = short_q;

endmodule

// File: tb/tb_esdi_write_deserializer.sv
// Directed bench: an 8-bit/depth-4 instance and a 32-bit/depth-16 instance share the pins; per-instance enables pick the target.
// Beats are captured into queues on the negative edge and compared against hand-computed words.
module tb_esdi_write_deserializer;

  localparam int HALF = 5;

  logic        aclk = 1'b0;
  logic        areset, clear_status;
  logic        en8, en32, rdy8, rdy32;
  logic [7:0]  sync_pattern;
  logic [15:0] sector_bytes;
  logic [7:0]  sector_number;
  logic        wgate, wclk, wdat;

  logic        m8_tvalid, m8_tlast, busy8, done8, ovf8, short8;
  logic [7:0]  m8_tdata, m8_tid;
  logic [0:0]  m8_tkeep;
  logic        m32_tvalid, m32_tlast, busy32, done32, ovf32, short32;
  logic [31:0] m32_tdata;
  logic [7:0]  m32_tid;
  logic [3:0]  m32_tkeep;

  logic [63:0] q8[$];
  logic [63:0] q32[$];
  int          done8_cnt = 0, done32_cnt = 0;
  int          n_vec = 0, n_bad = 0;
  int          d0;

  always #5 aclk = ~aclk;

  esdi_write_deserializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ID_WIDTH(8), .LEN_WIDTH(16)) u8 (
    .aclk(aclk), .areset(areset), .enable(en8), .clear_status(clear_status),
    .sync_pattern(sync_pattern), .sector_bytes(sector_bytes), .sector_number(sector_number),
    .esdi_write_gate(wgate), .esdi_write_clock(wclk), .esdi_write_data(wdat),
    .m_tvalid(m8_tvalid), .m_tready(rdy8), .m_tdata(m8_tdata), .m_tkeep(m8_tkeep),
    .m_tlast(m8_tlast), .m_tid(m8_tid), .busy(busy8), .done(done8),
    .overflow(ovf8), .short_error(short8));

  esdi_write_deserializer #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .ID_WIDTH(8), .LEN_WIDTH(16)) u32 (
    .aclk(aclk), .areset(areset), .enable(en32), .clear_status(clear_status),
    .sync_pattern(sync_pattern), .sector_bytes(sector_bytes), .sector_number(sector_number),
    .esdi_write_gate(wgate), .esdi_write_clock(wclk), .esdi_write_data(wdat),
    .m_tvalid(m32_tvalid), .m_tready(rdy32), .m_tdata(m32_tdata), .m_tkeep(m32_tkeep),
    .m_tlast(m32_tlast), .m_tid(m32_tid), .busy(busy32), .done(done32),
    .overflow(ovf32), .short_error(short32));

  function automatic logic [63:0] pk(input logic [7:0] tid, input logic last,
                                     input logic [3:0] keep, input logic [31:0] data);
    return {19'd0, tid, last, keep, data};
  endfunction

  always @(negedge aclk) begin
    if (m8_tvalid && rdy8)   q8.push_back(pk(m8_tid, m8_tlast, {3'b0, m8_tkeep}, {24'b0, m8_tdata}));
    if (m32_tvalid && rdy32) q32.push_back(pk(m32_tid, m32_tlast, m32_tkeep, m32_tdata));
    if (done8)  done8_cnt++;
    if (done32) done32_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect8(input string tag, input logic [63:0] exp);
    logic [63:0] got;
    got = '1;
    if (q8.size() != 0) got = q8.pop_front();
    check(tag, got, exp);
  endtask

  task automatic expect32(input string tag, input logic [63:0] exp);
    logic [63:0] got;
    got = '1;
    if (q32.size() != 0) got = q32.pop_front();
    check(tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wdat = b[i];
      cyc(HALF);
      wclk = 1'b1;
      cyc(HALF);
      wclk = 1'b0;
    end
  endtask

  task automatic gate_on;
    wgate = 1'b0;
    cyc(6);
  endtask

  task automatic gate_release;
    cyc(HALF);
    wgate = 1'b1;
    cyc(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    areset = 1'b1; clear_status = 1'b0; en8 = 1'b0; en32 = 1'b0;
    rdy8 = 1'b1; rdy32 = 1'b1; sync_pattern = 8'h5A; sector_bytes = 16'd3;
    sector_number = 8'd7; wgate = 1'b1; wclk = 1'b0; wdat = 1'b0;
    cyc(4);
    check("rst_tvalid",  m8_tvalid, 0);
    check("rst_tdata",   m8_tdata, 0);
    check("rst_tlast",   m8_tlast, 0);
    check("rst_tid",     m8_tid, 0);
    check("rst_busy",    busy8, 0);
    check("rst_done",    done8, 0);
    check("rst_ovf",     ovf8, 0);
    check("rst_short",   short8, 0);
    check("rst_tvalid32", m32_tvalid, 0);
    check("rst_tkeep32", m32_tkeep, 0);
    areset = 1'b0;
    cyc(4);

    // 8-bit basic sector
    en8 = 1'b1; sector_bytes = 16'd3; sector_number = 8'd7; d0 = done8_cnt;
    gate_on();
    check("t1_busy_hunt", busy8, 1);
    send_byte(8'h5A); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    gate_release();
    expect8("t1_b0", pk(8'd7, 1'b0, 4'h1, 32'h11));
    expect8("t1_b1", pk(8'd7, 1'b0, 4'h1, 32'h22));
    expect8("t1_b2", pk(8'd7, 1'b1, 4'h1, 32'h33));
    check("t1_extra", q8.size(), 0);
    check("t1_done", done8_cnt - d0, 1);
    check("t1_ovf", ovf8, 0);
    check("t1_short", short8, 0);
    check("t1_busy_idle", busy8, 0);
    en8 = 1'b0;

    // 32-bit packing with a partial final word
    en32 = 1'b1; sector_bytes = 16'd6; sector_number = 8'd3; d0 = done32_cnt;
    gate_on();
    send_byte(8'h5A);
    for (int b = 1; b <= 6; b++) send_byte(8'(b));
    gate_release();
    expect32("t2_b0", pk(8'd3, 1'b0, 4'hF, 32'h04030201));
    expect32("t2_b1", pk(8'd3, 1'b1, 4'h3, 32'h00000605));
    check("t2_extra", q32.size(), 0);
    check("t2_done", done32_cnt - d0, 1);
    check("t2_short", short32, 0);
    en32 = 1'b0;

    // 32-bit short sector: gate released after 2 of 4 bytes
    en32 = 1'b1; sector_bytes = 16'd4; sector_number = 8'd9; d0 = done32_cnt;
    gate_on();
    send_byte(8'h5A); send_byte(8'hAA); send_byte(8'hBB);
    gate_release();
    expect32("t3_b0", pk(8'd9, 1'b1, 4'h3, 32'h0000BBAA));
    check("t3_extra", q32.size(), 0);
    check("t3_done", done32_cnt - d0, 1);
    check("t3_short_set", short32, 1);
    check("t3_busy_idle", busy32, 0);
    cyc(5);
    check("t3_short_sticky", short32, 1);
    clear_status = 1'b1; cyc(1); clear_status = 1'b0;
    check("t3_short_clr", short32, 0);
    en32 = 1'b0;

    // 8-bit overflow with depth-4 FIFO and stalled sink
    rdy8 = 1'b0; en8 = 1'b1; sector_bytes = 16'd6; sector_number = 8'd5; d0 = done8_cnt;
    gate_on();
    send_byte(8'h5A);
    for (int b = 1; b <= 6; b++) send_byte(8'hA0 + 8'(b));
    gate_release();
    check("t4_ovf", ovf8, 1);
    check("t4_done", done8_cnt - d0, 1);
    check("t4_held_valid", m8_tvalid, 1);
    check("t4_held_data", m8_tdata, 8'hA1);
    rdy8 = 1'b1;
    cyc(10);
    expect8("t4_b0", pk(8'd5, 1'b0, 4'h1, 32'hA1));
    expect8("t4_b1", pk(8'd5, 1'b0, 4'h1, 32'hA2));
    expect8("t4_b2", pk(8'd5, 1'b0, 4'h1, 32'hA3));
    expect8("t4_b3", pk(8'd5, 1'b0, 4'h1, 32'hA4));
    check("t4_extra", q8.size(), 0);
    clear_status = 1'b1; cyc(1); clear_status = 1'b0;
    check("t4_ovf_clr", ovf8, 0);

    // gate cycle without any sync match
    d0 = done8_cnt;
    gate_on();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h33);
    check("t5_busy_hunt", busy8, 1);
    gate_release();
    check("t5_busy_idle", busy8, 0);
    check("t5_no_beats", q8.size(), 0);
    check("t5_no_done", done8_cnt - d0, 0);

    // reset mid-sector with two words queued, then a clean sector
    rdy8 = 1'b0; sector_bytes = 16'd4; sector_number = 8'd2;
    gate_on();
    send_byte(8'h5A); send_byte(8'h11); send_byte(8'h22);
    cyc(HALF);
    check("t6_queued", m8_tvalid, 1);
    areset = 1'b1; cyc(1);
    check("t6_rst_tvalid", m8_tvalid, 0);
    check("t6_rst_busy", busy8, 0);
    areset = 1'b0; wgate = 1'b1; rdy8 = 1'b1;
    cyc(10);
    check("t6_flushed", q8.size(), 0);
    sector_bytes = 16'd2; sector_number = 8'd4;
    gate_on();
    send_byte(8'h5A); send_byte(8'h77); send_byte(8'h88);
    gate_release();
    expect8("t6_b0", pk(8'd4, 1'b0, 4'h1, 32'h77));
    expect8("t6_b1", pk(8'd4, 1'b1, 4'h1, 32'h88));
    check("t6_extra", q8.size(), 0);
    en8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/esdi_write_deserializer.md
# esdi_write_deserializer

Parametrised ESDI write-path front end. It synchronises the drive-side write gate, write clock and NRZ write data into the fabric clock and hunts for a programmable sync byte. It then packs the following sector bytes into DATA_WIDTH-bit words and delivers them on an AXI4-Stream master through an internal FIFO. Each frame is tagged with the sector number current at sync, and its last word is marked with tlast and tkeep. It sits between the ESDI connector pins and the labeler/DMA stream path, and replaces the fixed 8-bit write datapath.

## Interface
- DATA_WIDTH, 8, stream word width; 8, 16 or 32.
- FIFO_DEPTH, 16, output FIFO words; power of two, ≥4.
- ID_WIDTH, 8, width of sector tag.
- LEN_WIDTH, 16, width of sector byte count.
- aclk  in  1  fabric clock; everything is synchronous to its rising edge.
- areset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; sampled only in IDLE.
- clear_status  in  1  single-cycle pulse; clears sticky overflow and short_error.
- sync_pattern  in  8  sync byte to match, MSB first.
- sector_bytes  in  LEN_WIDTH  payload bytes per sector; latched at sync.
- sector_number  in  ID_WIDTH  current sector from sector_timer; latched at sync.
- esdi_write_gate  in  1  active-low write gate, asynchronous.
- esdi_write_clock  in  1  write clock, asynchronous; data valid on rising edge.
- esdi_write_data  in  1  NRZ write data, asynchronous.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tdata  out  DATA_WIDTH  packed bytes; first byte in bits [7:0].
- m_tkeep  out  DATA_WIDTH/8  byte enables; all-ones except possibly on the tlast word.
- m_tlast  out  1  last word of sector.
- m_tid  out  ID_WIDTH  latched sector number.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when the tlast word is pushed.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- short_error  out  1  sticky: the gate deasserted before sector_bytes were received.

## Operation
- Gate, clock and data each pass through a 2-flop synchroniser. A write-clock rising edge is detected as synced 0→1 via one further register, and data is sampled from its synced copy on that same cycle.
- IDLE: go to HUNT when enable=1, synced gate=0 and sector_bytes≠0. Otherwise stay; sector_bytes=0 means never capture.
- HUNT: shift sampled bits into an 8-bit register, MSB first. On a match with sync_pattern, latch sector_bytes and sector_number, clear the counters and go to DATA. Gate deasserts → IDLE, with no output.
- DATA: 8 bits form a byte, MSB first. Bytes fill the word little-endian. Push to the FIFO when the word is full or the byte count reaches sector_bytes; the final push carries tlast=1 and the tkeep of the filled bytes. After the final push go to DRAIN.
- Gate deasserts in DATA:
  - partial byte bits are discarded;
  - a partial word, or an empty word with tkeep=0 if no bytes are pending, is pushed with tlast=1;
  - short_error is set and the block goes to DRAIN.
- DRAIN: ignore bits; return to IDLE when synced gate=1.
- FIFO full at push: the word is dropped and overflow is set. A dropped tlast word still fires done. The frame continues.
- enable deassertion outside IDLE takes effect only after the current sector.
- clear_status and a simultaneous set event in the same cycle leave the flag set.

## Timing
- Reset values: m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, busy, done, overflow and short_error are 0. The FIFO is empty, the state is IDLE and the synchronisers are cleared.
- Reset mid-sector aborts at once: queued words are lost, and m_tvalid is 0 on the cycle after areset.
- Pin-to-edge-detect latency is 3 aclk cycles.
- A word is pushed in the cycle after the edge that completes it. m_tvalid rises the cycle after the push when the FIFO was empty.
- AXI rules: tdata, tkeep, tlast and tid are held while tvalid=1 and tready=0. A transfer occurs when both are 1. A push and a pop in the same cycle are legal when the FIFO is full (no drop) or empty (pass-through after 1 cycle).
- Write clock high and low phases must each be ≥3 aclk cycles. Below that, behaviour is undefined.

## Structure
- Package esdi_pkg: state encoding (IDLE, HUNT, DATA, DRAIN), BYTE_BITS=8, and a KEEP_WIDTH function.
- Sub-module sync_fifo, a generic synchronous FIFO of width DATA_WIDTH+KEEP+1+ID_WIDTH and depth FIFO_DEPTH, with full and empty flags. It is reusable by the read path.

## Test plan
- DATA_WIDTH=8, sync_pattern=0x5A, sector_bytes=3, sector_number=7, bits 0x5A 0x11 0x22 0x33 at 5-cycle half-periods → three beats 0x11, 0x22, 0x33; the last has tlast=1 and tid=7, one done pulse, no errors.
- DATA_WIDTH=32, sector_bytes=6, payload 01..06 → beats 0x04030201 (tkeep=F) and 0x00000605 (tkeep=3, tlast=1).
- Gate released after 2 of 4 bytes (DATA_WIDTH=32) → one beat 0x0000BBAA, tkeep=3, tlast=1; short_error=1 until clear_status.
- m_tready=0, FIFO_DEPTH=4, sector_bytes=6 (8-bit) → 4 beats kept, bytes 5–6 dropped, overflow=1. Bytes 5–6 include the tlast byte, so done still pulses. After tready=1 the first 4 bytes drain in order.
- Gate low with no sync match, then gate released → no beats, busy returns to 0.
- areset asserted mid-sector with 2 words queued → m_tvalid=0 next cycle. The next sector is captured correctly.
